// File: rtl/counter_run_arbiter_pkg.sv
// Shared definitions for the counter run arbiter: counter width, mode encoding,
// FSM state codes and the run-length decode helper.
package counter_ctrl_pkg;

  localparam int CNT_W = 3;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  // A steps field of zero means a full lap of 2^CNT_W steps.
  function automatic logic [CNT_W:0] runLength(input logic [CNT_W-1:0] steps);
    return (steps == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, steps};
  endfunction

endpackage

// File: rtl/counter_run_arbiter_if.sv
// Request/grant bundle between the two requesters and the run arbiter.
interface counter_run_arbiter_if;
  import counter_ctrl_pkg::*;

  logic [1:0]       req;
  logic [1:0]       mode;
  logic [CNT_W-1:0] steps0;
  logic [CNT_W-1:0] steps1;
  logic [1:0]       grant;
  logic             busy;
  logic [1:0]       done;
  logic [CNT_W-1:0] count;

  modport master (
    output req, mode, steps0, steps1,
    input  grant, busy, done, count
  );

  modport slave (
    input  req, mode, steps0, steps1,
    output grant, busy, done, count
  );

endinterface

// File: rtl/counter_run_arbiter_counter.sv
// Wrapping up/down counter with enable; the arbiter owns enable and mode.
module updown_counter_en
  import counter_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             mode_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= (mode_i == MODE_DOWN) ? count_q - 1'b1 : count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_run_arbiter.sv
// Round-robin arbiter that lends the shared counter to one requester at a time
// for a run of N steps, then pulses done to that owner.
module counter_run_arbiter
  import counter_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  counter_run_arbiter_if.slave  bus
);

  logic [1:0]     state_q, state_d;
  logic           rr_q, rr_d;
  logic           owner_q, owner_d;
  logic           modeLat_q, modeLat_d;
  logic [CNT_W:0] remaining_q, remaining_d;
  logic           winner;
  logic           cntEn;
  logic [1:0]     ownerOneHot;

  // The pointed-to requester wins; the other only when the pointed one is idle.
  assign winner = bus.req[rr_q] ? rr_q : ~rr_q;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    modeLat_d   = modeLat_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req != 2'b00) begin
          owner_d     = winner;
          modeLat_d   = bus.mode[winner];
          remaining_d = runLength(winner ? bus.steps1 : bus.steps0);
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == {{CNT_W{1'b0}}, 1'b1}) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        rr_d    = ~owner_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      modeLat_q   <= MODE_UP;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      modeLat_q   <= modeLat_d;
      remaining_q <= remaining_d;
    end
  end

  assign cntEn = (state_q == ST_RUN);

  updown_counter_en uCounter (
    .clk     (clk),
    .reset   (reset),
    .en_i    (cntEn),
    .mode_i  (modeLat_q),
    .count_o (bus.count)
  );

  assign ownerOneHot = owner_q ? 2'b10 : 2'b01;
  assign bus.grant   = (state_q != ST_IDLE) ? ownerOneHot : 2'b00;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE) ? ownerOneHot : 2'b00;

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// random traffic checked against a run-timeline reference model.
module tb_counter_run_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  counter_run_arbiter_if bus();

  counter_run_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: when a run is granted, its whole per-cycle output
  // timeline is queued; each clock edge pops one entry.
  typedef struct {
    logic [1:0] grant;
    logic [1:0] done;
    int         count;
    int         newRr;
  } exp_t;

  exp_t plan[$];
  exp_t cur;
  int   mCount;
  int   mRr;

  function automatic exp_t mkExp(logic [1:0] g, logic [1:0] d, int c, int r);
    exp_t e;
    e.grant = g;
    e.done  = d;
    e.count = c;
    e.newRr = r;
    return e;
  endfunction

  task automatic modelStep(input logic rst, input logic [1:0] r, input logic [1:0] m,
                           input logic [2:0] s0, input logic [2:0] s1);
    int w, n, dir, fin;
    logic [1:0] g;
    if (rst) begin
      plan.delete();
      mCount = 0;
      mRr    = 0;
      cur    = mkExp(2'b00, 2'b00, 0, -1);
    end else begin
      if (plan.size() == 0 && r != 2'b00) begin
        w   = r[mRr] ? mRr : 1 - mRr;
        n   = (w == 0) ? int'(s0) : int'(s1);
        if (n == 0) n = 8;
        dir = m[w] ? -1 : 1;
        g   = (w == 0) ? 2'b01 : 2'b10;
        plan.push_back(mkExp(g, 2'b00, mCount, -1));
        for (int k = 1; k <= n; k++) begin
          plan.push_back(mkExp(g, (k == n) ? g : 2'b00, ((mCount + dir * k) % 8 + 8) % 8, -1));
        end
        fin = ((mCount + dir * n) % 8 + 8) % 8;
        plan.push_back(mkExp(2'b00, 2'b00, fin, 1 - w));
      end
      if (plan.size() > 0) begin
        cur    = plan.pop_front();
        mCount = cur.count;
        if (cur.newRr >= 0) mRr = cur.newRr;
      end else begin
        cur = mkExp(2'b00, 2'b00, mCount, -1);
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [1:0] r, input logic [1:0] m,
                               input logic [2:0] s0, input logic [2:0] s1);
    reset      = rst;
    bus.req    = r;
    bus.mode   = m;
    bus.steps0 = s0;
    bus.steps1 = s1;
    @(posedge clk);
    modelStep(rst, r, m, s0, s1);
    #1;
  endtask

  task automatic checkOutput(input string name);
    logic expBusy;
    expBusy = (cur.grant != 2'b00);
    checks++;
    if (bus.grant !== cur.grant || bus.busy !== expBusy || bus.done !== cur.done ||
        int'(bus.count) != cur.count || $isunknown(bus.count)) begin
      errors++;
      $display("[TB] FAIL %s: got grant=%b busy=%b done=%b count=%0d, need grant=%b busy=%b done=%b count=%0d",
               name, bus.grant, bus.busy, bus.done, bus.count, cur.grant, expBusy, cur.done, cur.count);
    end
  endtask

  task automatic checkConst(input string name, input int got, input int need);
    checks++;
    if (got != need) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, need %0d", name, got, need);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] mode;
    logic [2:0] s0;
    logic [2:0] s1;
    logic [1:0] eGrant;
    logic [1:0] eDone;
    logic [2:0] eCount;
  } vec_t;

  vec_t vecs[8];
  int   downSeq[8];

  initial begin : main
    logic [1:0] reqVec;
    int doneCount, startCount, seen;
    errors = 0;
    checks = 0;
    mCount = 0;
    mRr    = 0;
    cur    = mkExp(2'b00, 2'b00, 0, -1);

    vecs[0] = '{1'b1, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 2'b00, 3'd0};
    vecs[1] = '{1'b1, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 2'b00, 3'd0};
    vecs[2] = '{1'b0, 2'b01, 2'b00, 3'd3, 3'd0, 2'b01, 2'b00, 3'd0};
    vecs[3] = '{1'b0, 2'b01, 2'b00, 3'd3, 3'd0, 2'b01, 2'b00, 3'd1};
    vecs[4] = '{1'b0, 2'b01, 2'b00, 3'd3, 3'd0, 2'b01, 2'b00, 3'd2};
    vecs[5] = '{1'b0, 2'b01, 2'b00, 3'd3, 3'd0, 2'b01, 2'b01, 3'd3};
    vecs[6] = '{1'b0, 2'b00, 2'b00, 3'd3, 3'd0, 2'b00, 2'b00, 3'd3};
    vecs[7] = '{1'b0, 2'b00, 2'b00, 3'd3, 3'd0, 2'b00, 2'b00, 3'd3};
    downSeq = '{2, 1, 0, 7, 6, 5, 4, 3};

    // Reset then a single 3-step up run.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].mode, vecs[i].s0, vecs[i].s1);
      checkConst($sformatf("vec%0d grant", i), int'(bus.grant), int'(vecs[i].eGrant));
      checkConst($sformatf("vec%0d done", i), int'(bus.done), int'(vecs[i].eDone));
      checkConst($sformatf("vec%0d count", i), int'(bus.count), int'(vecs[i].eCount));
      checkOutput($sformatf("vec%0d model", i));
    end

    // Eight-step down run from 3 wraps through zero.
    applyStimulus(1'b0, 2'b10, 2'b10, 3'd0, 3'd0);
    checkConst("wrap grant", int'(bus.grant), 2);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 2'b10, 2'b10, 3'd0, 3'd0);
      checkConst($sformatf("wrap count%0d", k), int'(bus.count), downSeq[k]);
      checkOutput($sformatf("wrap model%0d", k));
    end
    checkConst("wrap done", int'(bus.done), 2);
    applyStimulus(1'b0, 2'b00, 2'b00, 3'd0, 3'd0);
    checkOutput("wrap idle");

    // Simultaneous requests after reset, owners drop req on done.
    applyStimulus(1'b1, 2'b00, 2'b00, 3'd0, 3'd0);
    reqVec = 2'b11;
    doneCount = 0;
    for (int c = 0; c < 14; c++) begin
      applyStimulus(1'b0, reqVec, 2'b00, 3'd2, 3'd2);
      checkOutput($sformatf("rr cyc%0d", c));
      if (bus.done != 2'b00) begin
        checkConst($sformatf("rr done%0d who", doneCount), int'(bus.done), (doneCount == 0) ? 1 : 2);
        checkConst($sformatf("rr done%0d count", doneCount), int'(bus.count), (doneCount == 0) ? 2 : 4);
        reqVec = reqVec & ~bus.done;
        doneCount++;
      end
    end
    checkConst("rr done total", doneCount, 2);
    reqVec = 2'b11;
    applyStimulus(1'b0, reqVec, 2'b00, 3'd2, 3'd2);
    checkConst("rr third grant", int'(bus.grant), 1);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, reqVec, 2'b00, 3'd2, 3'd2);
      checkOutput($sformatf("rr3 cyc%0d", c));
      reqVec = reqVec & ~bus.done;
    end

    // Input changes and req withdrawal mid-run are ignored.
    applyStimulus(1'b1, 2'b00, 2'b00, 3'd0, 3'd0);
    applyStimulus(1'b0, 2'b01, 2'b00, 3'd4, 3'd0);
    checkConst("midrun grant", int'(bus.grant), 1);
    startCount = int'(bus.count);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 2'b00, 2'b01, 3'd1, 3'd0);
      checkOutput($sformatf("midrun cyc%0d", c));
      if (bus.done != 2'b00) begin
        seen = 1;
        checkConst("midrun done", int'(bus.done), 1);
        checkConst("midrun count", int'(bus.count), (startCount + 4) % 8);
        break;
      end
    end
    checkConst("midrun done seen", seen, 1);
    applyStimulus(1'b0, 2'b00, 2'b00, 3'd0, 3'd0);

    // Reset on the second RUN cycle of a 5-step run.
    applyStimulus(1'b0, 2'b01, 2'b00, 3'd5, 3'd0);
    applyStimulus(1'b0, 2'b01, 2'b00, 3'd5, 3'd0);
    applyStimulus(1'b1, 2'b01, 2'b00, 3'd5, 3'd0);
    checkConst("rstmid count", int'(bus.count), 0);
    checkConst("rstmid grant", int'(bus.grant), 0);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 2'b00, 2'b00, 3'd5, 3'd0);
      checkConst($sformatf("rstmid nodone%0d", c), int'(bus.done), 0);
    end
    applyStimulus(1'b0, 2'b10, 2'b00, 3'd0, 3'd2);
    checkConst("rstmid regrant", int'(bus.grant), 2);

    // Requester 1 holds req past its done and is re-granted after one idle cycle.
    applyStimulus(1'b0, 2'b10, 2'b00, 3'd0, 3'd2);
    checkOutput("hold run1");
    applyStimulus(1'b0, 2'b10, 2'b00, 3'd0, 3'd2);
    checkConst("hold done", int'(bus.done), 2);
    applyStimulus(1'b0, 2'b10, 2'b00, 3'd0, 3'd2);
    checkConst("hold idle gap", int'(bus.grant), 0);
    applyStimulus(1'b0, 2'b10, 2'b00, 3'd0, 3'd2);
    checkConst("hold regrant", int'(bus.grant), 2);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 2'b00, 2'b00, 3'd0, 3'd2);
      checkOutput($sformatf("hold tail%0d", c));
    end

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 49) == 0), 2'($urandom), 2'($urandom),
                    3'($urandom), 3'($urandom));
      checkOutput($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
